alu_share_ctrl: RTL and testbench

Two-requester controller that time-shares the single combinational ALU in the execute stage. It accepts operation requests over valid/ready handshakes, arbitrates round-robin, drives the shared ALU's operand and op-code inputs, captures the result in one cycle, and returns it to the winning requester over a valid/ready response channel. Requester 0 is the integer execute path and requester 1 is the branch/address helper path; both see identical behaviour.

---
 rtl/alu_share_ctrl.sv | 104 ++++++++++
 tb/tb_alu_share_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Two-requester controller that time-shares one combinational ALU.
// Round-robin grant, one-cycle result capture, valid/ready response per requester.
module alu_share_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OP_CODE_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req_valid_0,
    output logic                     req_ready_0,
    input  logic [DATA_WIDTH-1:0]    req_in1_0,
    input  logic [DATA_WIDTH-1:0]    req_in2_0,
    input  logic [OP_CODE_WIDTH-1:0] req_op_0,
    output logic                     rsp_valid_0,
    input  logic                     rsp_ready_0,
    output logic [DATA_WIDTH-1:0]    rsp_data_0,
    output logic                     rsp_err_0,

    input  logic                     req_valid_1,
    output logic                     req_ready_1,
    input  logic [DATA_WIDTH-1:0]    req_in1_1,
    input  logic [DATA_WIDTH-1:0]    req_in2_1,
    input  logic [OP_CODE_WIDTH-1:0] req_op_1,
    output logic                     rsp_valid_1,
    input  logic                     rsp_ready_1,
    output logic [DATA_WIDTH-1:0]    rsp_data_1,
    output logic                     rsp_err_1,

    output logic [DATA_WIDTH-1:0]    alu_in1,
    output logic [DATA_WIDTH-1:0]    alu_in2,
    output logic [OP_CODE_WIDTH-1:0] alu_op_code,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam logic [OP_CODE_WIDTH-1:0] LAST_LEGAL_OP = OP_CODE_WIDTH'(9);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                  state;
    logic                    owner;
    logic                    prio;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    err_q;

    logic                    owner_rsp_ready;
    logic                    can_accept;
    logic                    any_valid;
    logic                    winner;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   win_in1;
    logic [DATA_WIDTH-1:0]   win_in2;
    logic [OP_CODE_WIDTH-1:0] win_op;

    // Arbitration: a lone requester wins outright, a tie goes to prio.
    always_comb begin
        owner_rsp_ready = owner ? rsp_ready_1 : rsp_ready_0;
        can_accept      = (state == IDLE) || ((state == RESP) && owner_rsp_ready);
        any_valid       = req_valid_0 || req_valid_1;
        winner          = (req_valid_0 && req_valid_1) ? prio : req_valid_1;
        accept          = can_accept && any_valid;
        win_in1         = winner ? req_in1_1 : req_in1_0;
        win_in2         = winner ? req_in2_1 : req_in2_0;
        win_op          = winner ? req_op_1  : req_op_0;
    end

    assign req_ready_0 = accept && !winner;
    assign req_ready_1 = accept &&  winner;

    // ALU sees zeros whenever nothing is being accepted.
    assign alu_in1     = accept ? win_in1 : '0;
    assign alu_in2     = accept ? win_in2 : '0;
    assign alu_op_code = accept ? win_op  : '0;

    assign rsp_valid_0 = (state == RESP) && !owner;
    assign rsp_valid_1 = (state == RESP) &&  owner;
    assign rsp_data_0  = rsp_valid_0 ? result_q : '0;
    assign rsp_data_1  = rsp_valid_1 ? result_q : '0;
    assign rsp_err_0   = rsp_valid_0 && err_q;
    assign rsp_err_1   = rsp_valid_1 && err_q;

    // Accept has precedence over a plain drain so back-to-back ops never bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            prio     <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            state    <= RESP;
            owner    <= winner;
            prio     <= !winner;
            result_q <= alu_result;
            err_q    <= (win_op > LAST_LEGAL_OP);
        end else if ((state == RESP) && owner_rsp_ready) begin
            state    <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed steps from the test plan, then random traffic
// checked against a transaction-level model of the controller and a behavioural ALU.
module tb_alu_share_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0, rsp_err_0;
    logic          req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1, rsp_err_1;
    logic [DW-1:0] req_in1_0, req_in2_0, req_in1_1, req_in2_1, rsp_data_0, rsp_data_1;
    logic [OW-1:0] req_op_0, req_op_1, alu_op_code;
    logic [DW-1:0] alu_in1, alu_in2, alu_result;

    int total = 0;
    int bad   = 0;

    // Stimulus per requester
    bit            v  [2];
    bit            rr [2];
    logic [DW-1:0] a  [2];
    logic [DW-1:0] b  [2];
    logic [OW-1:0] op [2];
    bit            granted [2];

    // Transaction-level model: at most one held result, tagged with its owner
    bit            m_held, m_owner, m_prio, m_err;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_WIDTH(DW), .OP_CODE_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_in1_0(req_in1_0), .req_in2_0(req_in2_0), .req_op_0(req_op_0),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_data_0(rsp_data_0), .rsp_err_0(rsp_err_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_in1_1(req_in1_1), .req_in2_1(req_in2_1), .req_op_1(req_op_1),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_data_1(rsp_data_1), .rsp_err_1(rsp_err_1),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op_code(alu_op_code),
        .alu_result(alu_result)
    );

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic [OW-1:0] o);
        case (o)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return x << y[4:0];
            4'd6: return x >> y[4:0];
            4'd7: return DW'($signed(x) >>> y[4:0]);
            4'd8: return DW'(x < y);
            4'd9: return DW'($signed(x) < $signed(y));
            default: return '0;
        endcase
    endfunction

    // The shared ALU the controller drives
    always_comb alu_result = alu_f(alu_in1, alu_in2, alu_op_code);

    always_comb begin
        req_valid_0 = v[0];  req_in1_0 = a[0];  req_in2_0 = b[0];  req_op_0 = op[0];
        req_valid_1 = v[1];  req_in1_1 = a[1];  req_in2_1 = b[1];  req_op_1 = op[1];
        rsp_ready_0 = rr[0];
        rsp_ready_1 = rr[1];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_owner = 0; m_prio = 0; m_err = 0; m_data = '0;
    endtask

    // One clock: check request side before the edge, response side after it.
    task automatic cyc();
        bit            free_slot, acc, win;
        logic [DW-1:0] exp_in1, exp_in2;
        logic [OW-1:0] exp_op;
        #1;
        free_slot = !m_held || rr[m_owner];
        acc       = free_slot && (v[0] || v[1]);
        win       = (v[0] && v[1]) ? m_prio : v[1];
        exp_in1   = acc ? a[win]  : '0;
        exp_in2   = acc ? b[win]  : '0;
        exp_op    = acc ? op[win] : '0;
        chk("req_ready_0", DW'(req_ready_0), DW'(acc && win == 0));
        chk("req_ready_1", DW'(req_ready_1), DW'(acc && win == 1));
        chk("alu_in1", alu_in1, exp_in1);
        chk("alu_in2", alu_in2, exp_in2);
        chk("alu_op",  DW'(alu_op_code), DW'(exp_op));
        granted[0] = acc && win == 0;
        granted[1] = acc && win == 1;
        @(posedge clk);
        #1;
        if (acc) begin
            m_held  = 1;
            m_owner = win;
            m_prio  = !win;
            m_data  = alu_f(a[win], b[win], op[win]);
            m_err   = op[win] > 4'd9;
        end else if (m_held && rr[m_owner]) begin
            m_held = 0;
        end
        chk("rsp_valid_0", DW'(rsp_valid_0), DW'(m_held && m_owner == 0));
        chk("rsp_valid_1", DW'(rsp_valid_1), DW'(m_held && m_owner == 1));
        chk("rsp_data_0",  rsp_data_0, (m_held && m_owner == 0) ? m_data : '0);
        chk("rsp_data_1",  rsp_data_1, (m_held && m_owner == 1) ? m_data : '0);
        chk("rsp_err_0",   DW'(rsp_err_0), DW'(m_held && m_owner == 0 && m_err));
        chk("rsp_err_1",   DW'(rsp_err_1), DW'(m_held && m_owner == 1 && m_err));
    endtask

    task automatic set_req(input int r, input bit val, input logic [DW-1:0] x,
                           input logic [DW-1:0] y, input logic [OW-1:0] o);
        v[r] = val; a[r] = x; b[r] = y; op[r] = o;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int r = 0; r < 2; r++) begin
            set_req(r, 0, '0, '0, '0);
            rr[r] = 1;
            granted[r] = 0;
        end
        model_reset();
        #2;
        chk("rst_rsp_valid_0", DW'(rsp_valid_0), '0);
        chk("rst_rsp_valid_1", DW'(rsp_valid_1), '0);
        chk("rst_rsp_data_0", rsp_data_0, '0);
        chk("rst_alu_in1", alu_in1, '0);
        chk("rst_alu_op", DW'(alu_op_code), '0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle drive
        cyc();
        chk("idle_alu_in2", alu_in2, '0);
        chk("idle_rsp_valid_0", DW'(rsp_valid_0), '0);

        // Contention: grants alternate 0,1,0,1 from reset priority
        set_req(0, 1, 32'd10, 32'd3, 4'd1);
        set_req(1, 1, 32'h8000_0000, 32'd4, 4'd7);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i % 2 == 0) begin
                chk("cont_valid_0", DW'(rsp_valid_0), 32'd1);
                chk("cont_data_0", rsp_data_0, 32'd7);
            end else begin
                chk("cont_valid_1", DW'(rsp_valid_1), 32'd1);
                chk("cont_data_1", rsp_data_1, 32'hF800_0000);
            end
        end
        set_req(0, 0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0);
        cyc();

        // Single request
        set_req(0, 1, 32'd5, 32'd7, 4'd0);
        #1;
        chk("single_ready_0", DW'(req_ready_0), 32'd1);
        cyc();
        chk("single_valid_0", DW'(rsp_valid_0), 32'd1);
        chk("single_data_0", rsp_data_0, 32'd12);
        chk("single_err_0", DW'(rsp_err_0), '0);
        chk("single_valid_1", DW'(rsp_valid_1), '0);
        set_req(0, 0, '0, '0, '0);
        cyc();

        // Backpressure on requester 1
        set_req(1, 1, 32'hFFFF_FFFF, 32'd1, 4'd9);
        rr[1] = 0;
        cyc();
        set_req(1, 0, '0, '0, '0);
        set_req(0, 1, 32'd1, 32'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_0", DW'(req_ready_0), '0);
            cyc();
            chk("bp_data_1", rsp_data_1, 32'd1);
        end
        rr[1] = 1;
        #1;
        chk("bp_release_ready_0", DW'(req_ready_0), 32'd1);
        cyc();
        chk("bp_after_data_0", rsp_data_0, 32'd2);
        set_req(0, 0, '0, '0, '0);
        cyc();

        // Illegal op then a legal one
        set_req(0, 1, 32'd3, 32'd4, 4'b1100);
        cyc();
        chk("ill_data_0", rsp_data_0, '0);
        chk("ill_err_0", DW'(rsp_err_0), 32'd1);
        set_req(0, 1, 32'd3, 32'd4, 4'd0);
        cyc();
        chk("legal_err_0", DW'(rsp_err_0), '0);
        chk("legal_data_0", rsp_data_0, 32'd7);
        set_req(0, 0, '0, '0, '0);
        cyc();

        // Reset while a result is held
        set_req(0, 1, 32'h1000, 32'h234, 4'd0);
        rr[0] = 0;
        cyc();
        set_req(0, 0, '0, '0, '0);
        chk("hold_data_0", rsp_data_0, 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid_0", DW'(rsp_valid_0), '0);
        chk("midrst_data_0", rsp_data_0, '0);
        model_reset();
        rr[0] = 1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 1, 32'd9, 32'd1, 4'd1);
        set_req(1, 1, 32'd9, 32'd1, 4'd0);
        #1;
        chk("postrst_tie_ready_0", DW'(req_ready_0), 32'd1);
        chk("postrst_tie_ready_1", DW'(req_ready_1), '0);
        cyc();
        chk("postrst_data_0", rsp_data_0, 32'd8);

        // Random traffic; a requester holds its operation until granted
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] || granted[r]) begin
                    v[r]  = $urandom_range(0, 3) != 0;
                    a[r]  = $urandom;
                    b[r]  = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 40));
                    op[r] = OW'($urandom_range(0, 15));
                end
                rr[r] = $urandom_range(0, 3) != 0;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
